// File: rtl/motor_pkg.sv
// Shared types for the dual H-bridge driver: per-side state encoding and
// the 2-bit side command values coming from the steering logic.
package motor_pkg;

   typedef enum logic [2:0] {
      COAST = 3'd0,
      BRAKE = 3'd1,
      RUN_A = 3'd2,
      RUN_B = 3'd3,
      DEAD  = 3'd4
   } side_state_e;

   localparam logic [1:0] CMD_COAST = 2'b00;
   localparam logic [1:0] CMD_A     = 2'b10;
   localparam logic [1:0] CMD_B     = 2'b01;
   localparam logic [1:0] CMD_BRAKE = 2'b11;

   // Steady state a side settles in for a given command (DEAD is never a target).
   function automatic side_state_e state_for(input logic [1:0] cmd);
      side_state_e s;
      case (cmd)
         CMD_A:     s = RUN_A;
         CMD_B:     s = RUN_B;
         CMD_BRAKE: s = BRAKE;
         default:   s = COAST;
      endcase
      return s;
   endfunction

   function automatic logic [1:0] pins_for(input side_state_e s);
      logic [1:0] p;
      case (s)
         RUN_A:   p = CMD_A;
         RUN_B:   p = CMD_B;
         BRAKE:   p = CMD_BRAKE;
         default: p = CMD_COAST;
      endcase
      return p;
   endfunction

   function automatic logic is_run(input side_state_e s);
      return (s == RUN_A) || (s == RUN_B);
   endfunction

endpackage

// File: rtl/bridge_side.sv
// One H-bridge side: state machine, soft-start duty register and dead-time
// counter. Outputs are registered from the next state.
module bridge_side
   import motor_pkg::*;
#(
   parameter int PWM_BITS    = 8,
   parameter int DUTY_MAX    = 200,
   parameter int RAMP_STEP   = 8,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          cmd_i,
   input  logic                period_tick_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic [1:0]          in_o,
   output logic                en_o,
   output logic                dead_o
);

   localparam int DCW = $clog2(DEAD_CYCLES + 1);
   localparam logic [DCW-1:0]      DEAD_LOAD  = DCW'(DEAD_CYCLES - 1);
   localparam logic [DCW-1:0]      DEAD_ONE   = DCW'(1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX_N = PWM_BITS'(DUTY_MAX);
   localparam logic [PWM_BITS:0]   STEP_W     = (PWM_BITS + 1)'(RAMP_STEP);

   side_state_e         state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [DCW-1:0]      dead_cnt_q, dead_cnt_d;
   logic [1:0]          in_q;
   logic                en_q, dead_q;

   side_state_e         target;
   logic [PWM_BITS:0]   duty_sum;
   logic [PWM_BITS-1:0] duty_ramped;

   assign target      = state_for(cmd_i);
   // One extra bit so the sum can exceed the limit without wrapping before we clamp.
   assign duty_sum    = {1'b0, duty_q} + STEP_W;
   assign duty_ramped = (duty_sum > {1'b0, DUTY_MAX_N}) ? DUTY_MAX_N : duty_sum[PWM_BITS-1:0];

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      dead_cnt_d = dead_cnt_q;
      case (state_q)
         COAST, BRAKE: begin
            state_d = target;
            duty_d  = '0;
         end
         RUN_A, RUN_B: begin
            if (target == state_q) begin
               if (period_tick_i) duty_d = duty_ramped;
            end else if (is_run(target)) begin
               state_d    = DEAD;
               duty_d     = '0;
               dead_cnt_d = DEAD_LOAD;
            end else begin
               state_d = target;
               duty_d  = '0;
            end
         end
         DEAD: begin
            duty_d = '0;
            // The exit always follows the command accepted now, never the one that caused the reversal.
            if (!is_run(target) || dead_cnt_q == '0) state_d = target;
            else dead_cnt_d = dead_cnt_q - DEAD_ONE;
         end
         default: begin
            state_d = COAST;
            duty_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= COAST;
         duty_q     <= '0;
         dead_cnt_q <= '0;
         in_q       <= CMD_COAST;
         en_q       <= 1'b0;
         dead_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         dead_cnt_q <= dead_cnt_d;
         in_q       <= pins_for(state_d);
         en_q       <= (state_d == BRAKE) || (is_run(state_d) && (pwm_cnt_i < duty_d));
         dead_q     <= (state_d == DEAD);
      end
   end

   assign in_o   = in_q;
   assign en_o   = en_q;
   assign dead_o = dead_q;

endmodule

// File: rtl/motor_bridge_driver.sv
// Dual H-bridge driver: command synchronizer and stability filter, shared
// PWM counter, and one bridge_side instance per wheel.
module motor_bridge_driver
   import motor_pkg::*;
#(
   parameter int PWM_BITS      = 8,
   parameter int DUTY_MAX      = 200,
   parameter int RAMP_STEP     = 8,
   parameter int DEAD_CYCLES   = 16,
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] motor_cmd,
   output logic [1:0] in_l,
   output logic [1:0] in_r,
   output logic       en_l,
   output logic       en_r,
   output logic       dead_l,
   output logic       dead_r
);

   localparam int SCW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SCW-1:0]      STAB_ONE  = SCW'(1);
   localparam logic [SCW-1:0]      STAB_LAST = SCW'(STABLE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

   logic [3:0]          sync1_q, sync2_q;
   logic [3:0]          cand_q, cand_d;
   logic [3:0]          acc_q, acc_d;
   logic [SCW-1:0]      stab_q, stab_d;
   logic [PWM_BITS-1:0] pwm_q;
   logic                period_tick;

   logic [1:0] side_in   [2];
   logic       side_en   [2];
   logic       side_dead [2];

   // A candidate is accepted after STABLE_CYCLES identical synced samples that differ from the accepted value.
   always_comb begin
      cand_d = cand_q;
      acc_d  = acc_q;
      stab_d = stab_q;
      if (sync2_q == acc_q) begin
         stab_d = '0;
      end else if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         stab_d = STAB_ONE;
      end else if (stab_q == STAB_LAST) begin
         acc_d  = sync2_q;
         stab_d = '0;
      end else begin
         stab_d = stab_q + STAB_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         acc_q   <= '0;
         stab_q  <= '0;
         pwm_q   <= '0;
      end else begin
         sync1_q <= motor_cmd;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         acc_q   <= acc_d;
         stab_q  <= stab_d;
         pwm_q   <= pwm_q + PWM_ONE;
      end
   end

   assign period_tick = &pwm_q;

   // Side 0 is the right wheel (cmd[1:0]), side 1 the left wheel (cmd[3:2]).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_side
         bridge_side #(
            .PWM_BITS   (PWM_BITS),
            .DUTY_MAX   (DUTY_MAX),
            .RAMP_STEP  (RAMP_STEP),
            .DEAD_CYCLES(DEAD_CYCLES)
         ) u_side (
            .clk          (clk),
            .rst_n        (rst_n),
            .cmd_i        (acc_q[2*gi +: 2]),
            .period_tick_i(period_tick),
            .pwm_cnt_i    (pwm_q),
            .in_o         (side_in[gi]),
            .en_o         (side_en[gi]),
            .dead_o       (side_dead[gi])
         );
      end
   endgenerate

   assign in_r   = side_in[0];
   assign en_r   = side_en[0];
   assign dead_r = side_dead[0];
   assign in_l   = side_in[1];
   assign en_l   = side_en[1];
   assign dead_l = side_dead[1];

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Bench for motor_bridge_driver: behavioural model compared every cycle,
// plus directed checks on latency, ramp, dead-time, glitch filter and reset.
module tb_motor_bridge_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] motor_cmd = 4'b0000;
   logic [1:0] in_l, in_r;
   logic       en_l, en_r, dead_l, dead_r;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   motor_bridge_driver dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .motor_cmd(motor_cmd),
      .in_l     (in_l),
      .in_r     (in_r),
      .en_l     (en_l),
      .en_r     (en_r),
      .dead_l   (dead_l),
      .dead_r   (dead_r)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [3:0] samp_q[$];
   logic [3:0] m_acc;
   int         m_cnt;
   int         m_dir   [2];   // 0 none, 1 direction A, 2 direction B
   int         m_brake [2];
   int         m_dead  [2];   // clocks of dead-time still to spend, 0 = not in dead-time
   int         m_duty  [2];
   logic [1:0] exp_in   [2];
   logic       exp_en   [2];
   logic       exp_dead [2];

   task automatic model_reset();
      samp_q = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      m_acc  = 4'h0;
      m_cnt  = 0;
      for (int s = 0; s < 2; s++) begin
         m_dir[s] = 0; m_brake[s] = 0; m_dead[s] = 0; m_duty[s] = 0;
         exp_in[s] = 2'b00; exp_en[s] = 1'b0; exp_dead[s] = 1'b0;
      end
   endtask

   task automatic side_step(input int s, input logic [1:0] c, input bit tick);
      bit stop_cmd;
      int want;
      stop_cmd = (c == 2'b00) || (c == 2'b11);
      want     = (c == 2'b10) ? 1 : 2;
      if (m_dead[s] > 0) begin
         if (stop_cmd) begin
            m_dead[s] = 0; m_dir[s] = 0; m_brake[s] = (c == 2'b11);
         end else if (m_dead[s] == 1) begin
            m_dead[s] = 0; m_dir[s] = want; m_duty[s] = 0;
         end else begin
            m_dead[s] = m_dead[s] - 1;
         end
      end else if (stop_cmd) begin
         m_dir[s] = 0; m_brake[s] = (c == 2'b11); m_duty[s] = 0;
      end else begin
         m_brake[s] = 0;
         if (m_dir[s] == 0) begin
            m_dir[s] = want; m_duty[s] = 0;
         end else if (m_dir[s] == want) begin
            if (tick) m_duty[s] = (m_duty[s] + 8 > 200) ? 200 : m_duty[s] + 8;
         end else begin
            m_dead[s] = 16; m_dir[s] = 0; m_duty[s] = 0;
         end
      end
      exp_dead[s] = (m_dead[s] > 0);
      if (m_dead[s] > 0)      begin exp_in[s] = 2'b00; exp_en[s] = 1'b0; end
      else if (m_brake[s] != 0) begin exp_in[s] = 2'b11; exp_en[s] = 1'b1; end
      else if (m_dir[s] == 1) begin exp_in[s] = 2'b10; exp_en[s] = (m_cnt < m_duty[s]); end
      else if (m_dir[s] == 2) begin exp_in[s] = 2'b01; exp_en[s] = (m_cnt < m_duty[s]); end
      else                    begin exp_in[s] = 2'b00; exp_en[s] = 1'b0; end
   endtask

   task automatic model_step();
      logic [3:0] synced;
      bit         accept;
      bit         tick;
      tick = (m_cnt == 255);
      samp_q.push_back(motor_cmd);
      // The filter sees inputs two clocks late and wants four equal samples.
      synced = samp_q[$-2];
      accept = (synced != m_acc);
      for (int k = 3; k <= 5; k++) if (samp_q[$-k] != synced) accept = 1'b0;
      for (int s = 0; s < 2; s++) side_step(s, m_acc[2*s +: 2], tick);
      if (accept) m_acc = synced;
      m_cnt = (m_cnt + 1) % 256;
      if (samp_q.size() > 16) void'(samp_q.pop_front());
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         check("left_side",  {in_l, en_l, dead_l}, {exp_in[1], exp_en[1], exp_dead[1]});
         check("right_side", {in_r, en_r, dead_r}, {exp_in[0], exp_en[0], exp_dead[0]});
      end
   end

   // ---------------- stimulus and directed checks ----------------
   int  edges, cnt_l, cnt_r, hold;
   bit  got, changed, saw_dead_l, saw_dead_r;

   initial begin
      // Reset held: command toggles must not reach the pins.
      repeat (3) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2 motor_cmd = (i % 2 == 0) ? 4'b1010 : 4'b0000;
      end
      motor_cmd = 4'b1010;
      repeat (2) @(negedge clk);
      check("reset_hold_outputs", {in_l, in_r, en_l, en_r, dead_l, dead_r}, 8'h00);
      @(posedge clk); #2 motor_cmd = 4'b0000;
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_idle", {in_l, in_r}, 4'b0000);

      // Acceptance latency.
      @(posedge clk); #2 motor_cmd = 4'b1010;
      edges = 0; got = 1'b0;
      while (!got && edges < 20) begin
         @(posedge clk); #1 edges++;
         if (in_l == 2'b10 && in_r == 2'b10) got = 1'b1;
      end
      check("accept_latency", edges, 7);
      check("accept_en_low", {en_l, en_r, dead_l, dead_r}, 4'b0000);

      // Soft-start ramp reaches saturation and holds.
      repeat (27 * 256) @(posedge clk);
      cnt_l = 0; cnt_r = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (en_l) cnt_l++;
         if (en_r) cnt_r++;
      end
      check("sat_duty_left", cnt_l, 200);
      check("sat_duty_right", cnt_r, 200);

      // Reversal on both sides inserts dead-time.
      @(posedge clk); #2 motor_cmd = 4'b0101;
      edges = 0;
      do begin @(negedge clk); edges++; end while (!dead_l && edges < 20);
      cnt_l = 0;
      while (dead_l && cnt_l < 40) begin
         cnt_l++;
         @(negedge clk);
      end
      check("dead_time_len", cnt_l, 16);
      check("after_dead_pins", {in_l, en_l, in_r}, 5'b01_0_01);

      // Glitch filter: 3-clock pulse ignored.
      @(posedge clk); #2 motor_cmd = 4'b1010;
      repeat (60) @(posedge clk);
      #2 motor_cmd = 4'b0110;
      repeat (3) @(posedge clk);
      #2 motor_cmd = 4'b1010;
      changed = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (in_l != 2'b10 || in_r != 2'b10 || dead_l || dead_r) changed = 1'b1;
      end
      check("glitch_3clk_ignored", changed, 1'b0);

      // 6-clock pulse is accepted: only the left side reverses.
      @(posedge clk); #2 motor_cmd = 4'b0110;
      repeat (6) @(posedge clk);
      #2 motor_cmd = 4'b1010;
      saw_dead_l = 1'b0; saw_dead_r = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (dead_l) saw_dead_l = 1'b1;
         if (dead_r) saw_dead_r = 1'b1;
      end
      check("glitch_6clk_accepted", {saw_dead_l, saw_dead_r}, 2'b10);

      // Coast during dead-time aborts it as soon as it is accepted.
      repeat (40) @(posedge clk);
      #2 motor_cmd = 4'b0101;
      edges = 0;
      do begin @(negedge clk); edges++; end while (!dead_l && edges < 20);
      @(posedge clk); #2 motor_cmd = 4'b0000;
      edges = 0;
      while (dead_l && edges < 20) begin
         @(posedge clk); #1 edges++;
      end
      check("dead_abort_latency", edges, 7);
      check("dead_abort_pins", {in_l, dead_l, in_r, dead_r}, 6'b00_0_00_0);

      // Randomized command sequences, occasionally held long enough to ramp.
      for (int n = 0; n < 300; n++) begin
         @(posedge clk); #2 motor_cmd = 4'($urandom_range(0, 15));
         hold = ($urandom_range(0, 9) == 0) ? 700 : $urandom_range(1, 30);
         repeat (hold) @(posedge clk);
      end

      // Asynchronous reset while ramping.
      @(posedge clk); #2 motor_cmd = 4'b1010;
      edges = 0;
      do begin @(negedge clk); edges++; end while (!(en_l && en_r) && edges < 3000);
      check("ramp_before_reset", {en_l, en_r}, 2'b11);
      #1 rst_n = 1'b0;
      #1 check("async_reset", {in_l, in_r, en_l, en_r, dead_l, dead_r}, 8'h00);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_bridge_driver.md
Name: motor_bridge_driver

Overview:
- Consumes the 4-bit motor command produced by the line-following steering logic and drives a dual H-bridge (L298-style: two direction pins plus one PWM enable per side).
- Provides command input synchronization and glitch filtering, a PWM soft-start ramp, and dead-time insertion on direction reversal.
- Sits between the steering logic and the board pins; one instance drives both wheels.

Parameters:
PWM_BITS, 8, width of the free-running PWM counter (period = 2^PWM_BITS clocks)
DUTY_MAX, 200, saturation value of the per-side duty register
RAMP_STEP, 8, duty increment applied once per PWM period while running
DEAD_CYCLES, 16, clocks with both direction pins low on an A<->B reversal
STABLE_CYCLES, 4, consecutive identical synced samples required to accept a new command

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
motor_cmd  input  4  [3:2]=left pair, [1:0]=right pair; per side 00 coast, 10 dir A, 01 dir B, 11 brake
in_l  output  2  left bridge direction pins
in_r  output  2  right bridge direction pins
en_l  output  1  left bridge PWM enable
en_r  output  1  right bridge PWM enable
dead_l  output  1  left side in dead-time
dead_r  output  1  right side in dead-time

Behaviour:
- One clock. Reset is asynchronous and active-low. All flops clear on rst_n low, independent of clk.
- Reset values: in_l=in_r=00, en_l=en_r=0, dead_l=dead_r=0. Both sides start in COAST. Accepted cmd=0000, duty=0, pwm_cnt=0, stability counter=0.
- Input path:
  - motor_cmd passes through a 2-flop synchronizer.
  - The synced value becomes the accepted cmd once it has differed from the accepted cmd and been identical for STABLE_CYCLES consecutive clocks.
  - Any change in the synced value restarts the stability count.
- Latency: a clean step on motor_cmd reaches in_x exactly 3+STABLE_CYCLES rising edges later (7 at default). All outputs are registered.
- PWM:
  - pwm_cnt increments every clock and wraps from 2^PWM_BITS-1 to 0.
  - period_tick is asserted when pwm_cnt is at its maximum value.
  - In RUN states, en_x = (pwm_cnt < duty_x), registered.
- Per-side FSM states: COAST, BRAKE, RUN_A, RUN_B, DEAD.
  - COAST: in=00, en=0, duty=0.
  - BRAKE: in=11, en=1 (constant), duty=0.
  - RUN_A: in=10. RUN_B: in=01. en is PWM-driven in both.
  - DEAD: in=00, en=0, dead_x=1, dead counter loaded with DEAD_CYCLES-1.
- Transitions:
  - COAST/BRAKE -> RUN_A/RUN_B: immediate, duty starts at 0.
  - COAST <-> BRAKE: immediate.
  - RUN_A -> RUN_B or RUN_B -> RUN_A: go to DEAD; duty cleared.
  - DEAD expiry: after DEAD_CYCLES clocks in DEAD, go to the state given by the current accepted side cmd. The state after DEAD is never chosen from a stale command.
  - DEAD with a coast or brake command accepted: exit immediately to COAST or BRAKE.
  - RUN -> COAST/BRAKE: immediate, duty cleared.
  - Same command re-accepted, or no change: hold state and duty.
- Ramp: in RUN, on period_tick, duty = min(duty+RAMP_STEP, DUTY_MAX). Compute with PWM_BITS+1 bits and saturate; the duty never wraps.
- Duty changes only on period_tick, so en_x never glitches mid-period from a ramp update.
- Sides are fully independent. Simultaneous reversals on both sides each insert their own dead-time.
- Reset asserted mid-operation (including mid-DEAD or mid-ramp): outputs go to reset values within the same cycle, asynchronously.

Decomposition:
- Shared package motor_pkg holds:
  - side-state enum (COAST, BRAKE, RUN_A, RUN_B, DEAD);
  - 2-bit side command constants (CMD_COAST=00, CMD_A=10, CMD_B=01, CMD_BRAKE=11).
- Sub-module bridge_side: one FSM with its duty register and dead counter, instantiated twice (left, right).
- Top level holds: the synchronizer, the stability filter, and the shared PWM counter/period_tick.

Test Plan:
- Reset check: hold rst_n low, toggle motor_cmd=1010 -> all outputs 0. Release rst_n -> in_l=in_r=00 persists until a command is accepted.
- Acceptance latency: step motor_cmd 0000->1010 -> in_l=10, in_r=10 exactly 7 edges later. dead_l/dead_r stay 0. en_x is low until the first period_tick raises duty to 8.
- Soft-start ramp: hold 1010 -> duty reaches 200 after 25 periods and stays 200. en_x high for exactly 200 of 256 clocks per period thereafter.
- Reversal: from steady 1010 apply 0101 -> in_l goes 00 with dead_l=1 for exactly 16 clocks, then in_l=01 with duty restarting at 0. Right side behaves the same, independently.
- Glitch filter: pulse motor_cmd to 0110 for 3 clocks, then return to 1010 -> no output change. A pulse of 6 clocks -> accepted.
- DEAD abort and async reset: during DEAD apply 0000 -> in_l=00, dead_l=0, COAST immediately after acceptance. Assert rst_n mid-ramp -> en_x=0 in the same cycle without a clk edge.
